// File: rtl/ctrl_decode_pipe.sv
// Instruction decoder with a one-entry output register, valid/ready handshake and a
// fixed-latency mult/div wait. Optional perf counters: define CTRL_DECODE_PIPE_PERF_EN.
module ctrl_decode_pipe #(
    parameter int MD_CYCLES = 17,
    parameter int INSN_W    = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [INSN_W-1:0] in_insn,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [14:0]       out_ctrl,
    output logic [4:0]        out_wreg,
    output logic              md_busy,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam int C_RWE     = 0;
    localparam int C_RD_SRC  = 1;
    localparam int C_ALU_INB = 2;
    localparam int C_DMWE    = 3;
    localparam int C_LW      = 4;
    localparam int C_JAL     = 5;
    localparam int C_BNE     = 6;
    localparam int C_BLT     = 7;
    localparam int C_BEX     = 8;
    localparam int C_JUMP    = 9;
    localparam int C_JR      = 10;
    localparam int C_SETX    = 11;
    localparam int C_MULT    = 12;
    localparam int C_DIV     = 13;
    localparam int C_ILLEGAL = 14;

    localparam logic [7:0] MD_CNT_INIT = 8'(MD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_MDWAIT = 2'd2
    } state_t;

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic        out_valid_reg;
    logic        md_busy_reg;
    logic [14:0] out_ctrl_reg;
    logic [4:0]  out_wreg_reg;

    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  aluop;
    logic [14:0] dec_ctrl;
    logic [4:0]  dec_wreg;
    logic        dec_is_md;
    logic        accept;

    // Only the opcode, rd and aluop fields are decoded; the rest are don't-care.
    logic unused_insn_bits;
    assign unused_insn_bits = ^in_insn;

    assign opcode = in_insn[31:27];
    assign rd     = in_insn[26:22];
    assign aluop  = in_insn[6:2];

    always_comb begin
        dec_ctrl = '0;
        unique case (opcode)
            OP_R: begin
                dec_ctrl[C_RWE]  = 1'b1;
                dec_ctrl[C_MULT] = (aluop == ALU_MULT);
                dec_ctrl[C_DIV]  = (aluop == ALU_DIV);
            end
            OP_J: begin
                dec_ctrl[C_JUMP] = 1'b1;
            end
            OP_BNE: begin
                dec_ctrl[C_RD_SRC] = 1'b1;
                dec_ctrl[C_BNE]    = 1'b1;
            end
            OP_JAL: begin
                dec_ctrl[C_RWE]  = 1'b1;
                dec_ctrl[C_JAL]  = 1'b1;
                dec_ctrl[C_JUMP] = 1'b1;
            end
            OP_JR: begin
                dec_ctrl[C_RD_SRC] = 1'b1;
                dec_ctrl[C_JR]     = 1'b1;
            end
            OP_ADDI: begin
                dec_ctrl[C_RWE]     = 1'b1;
                dec_ctrl[C_ALU_INB] = 1'b1;
            end
            OP_BLT: begin
                dec_ctrl[C_RD_SRC] = 1'b1;
                dec_ctrl[C_BLT]    = 1'b1;
            end
            OP_SW: begin
                dec_ctrl[C_RD_SRC]  = 1'b1;
                dec_ctrl[C_ALU_INB] = 1'b1;
                dec_ctrl[C_DMWE]    = 1'b1;
            end
            OP_LW: begin
                dec_ctrl[C_RWE]     = 1'b1;
                dec_ctrl[C_ALU_INB] = 1'b1;
                dec_ctrl[C_LW]      = 1'b1;
            end
            OP_SETX: begin
                dec_ctrl[C_RWE]  = 1'b1;
                dec_ctrl[C_SETX] = 1'b1;
            end
            OP_BEX: begin
                dec_ctrl[C_BEX] = 1'b1;
            end
            default: begin
                dec_ctrl[C_ILLEGAL] = 1'b1;
            end
        endcase
    end

    // jal and setx write fixed link/status registers; non-writers report r0.
    always_comb begin
        dec_wreg = 5'd0;
        if (dec_ctrl[C_RWE]) begin
            if (dec_ctrl[C_JAL])
                dec_wreg = 5'd31;
            else if (dec_ctrl[C_SETX])
                dec_wreg = 5'd30;
            else
                dec_wreg = rd;
        end
    end

    assign dec_is_md = dec_ctrl[C_MULT] | dec_ctrl[C_DIV];

    assign in_ready = !flush && ((state_reg == ST_IDLE) ||
                                 ((state_reg == ST_HOLD) && out_ready));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 8'd0;
            out_valid_reg <= 1'b0;
            md_busy_reg   <= 1'b0;
            out_ctrl_reg  <= '0;
            out_wreg_reg  <= '0;
        end else if (flush) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 8'd0;
            out_valid_reg <= 1'b0;
            md_busy_reg   <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        // The decoded word is captured now and exposed once the wait ends.
                        out_ctrl_reg <= dec_ctrl;
                        out_wreg_reg <= dec_wreg;
                        if (dec_is_md) begin
                            state_reg     <= ST_MDWAIT;
                            cnt_reg       <= MD_CNT_INIT;
                            out_valid_reg <= 1'b0;
                            md_busy_reg   <= 1'b1;
                        end else begin
                            state_reg     <= ST_HOLD;
                            out_valid_reg <= 1'b1;
                            md_busy_reg   <= 1'b0;
                        end
                    end else if ((state_reg == ST_HOLD) && out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_MDWAIT: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg     <= ST_HOLD;
                        out_valid_reg <= 1'b1;
                        md_busy_reg   <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cnt_reg       <= 8'd0;
                    out_valid_reg <= 1'b0;
                    md_busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign md_busy   = md_busy_reg;
    assign out_ctrl  = out_ctrl_reg;
    assign out_wreg  = out_wreg_reg;

`ifdef CTRL_DECODE_PIPE_PERF_EN
    logic [1:0]  perf_event;
    logic [31:0] perf_cnt_reg [2];

    assign perf_event[0] = out_valid_reg && out_ready;
    assign perf_event[1] = in_valid && !in_ready;

    // Free-running counters; they wrap naturally and only reset clears them.
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                perf_cnt_reg[gi] <= 32'd0;
            else if (perf_event[gi])
                perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
        end
    end

    assign perf_retired = perf_cnt_reg[0];
    assign perf_stall   = perf_cnt_reg[1];
`else
    assign perf_retired = 32'd0;
    assign perf_stall   = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Randomized self-checking bench for ctrl_decode_pipe against a transaction-level model
// (pending item + edges-until-visible), plus directed scenarios.
module tb_ctrl_decode_pipe;

    localparam int MD = 4;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_insn;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_ctrl;
    logic [4:0]  out_wreg;
    logic        md_busy;
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;

    int tests_run  = 0;
    int tests_fail = 0;

    // Model state: one pending decoded instruction, visible when m_wait reaches 0.
    bit          m_has;
    int          m_wait;
    logic [14:0] m_ctrl;
    logic [4:0]  m_wreg;
    logic [31:0] m_retired;
    logic [31:0] m_stall;

    logic [4:0] legal_ops [11];

    ctrl_decode_pipe #(.MD_CYCLES(MD), .INSN_W(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_insn      (in_insn),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_wreg     (out_wreg),
        .md_busy      (md_busy),
        .perf_retired (perf_retired),
        .perf_stall   (perf_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word per opcode, written as whole hex constants.
    function automatic void expect_decode(input logic [31:0] insn, output logic [14:0] ctrl,
                                          output logic [4:0] wreg, output bit md);
        logic [4:0] op;
        logic [4:0] alu;
        op  = insn[31:27];
        alu = insn[6:2];
        case (op)
            5'd0:    ctrl = (alu == 5'd6) ? 15'h1001 : ((alu == 5'd7) ? 15'h2001 : 15'h0001);
            5'd1:    ctrl = 15'h0200;
            5'd2:    ctrl = 15'h0042;
            5'd3:    ctrl = 15'h0221;
            5'd4:    ctrl = 15'h0402;
            5'd5:    ctrl = 15'h0005;
            5'd6:    ctrl = 15'h0082;
            5'd7:    ctrl = 15'h000E;
            5'd8:    ctrl = 15'h0015;
            5'd21:   ctrl = 15'h0801;
            5'd22:   ctrl = 15'h0100;
            default: ctrl = 15'h4000;
        endcase
        if (op == 5'd3)       wreg = 5'd31;
        else if (op == 5'd21) wreg = 5'd30;
        else if (op == 5'd0 || op == 5'd5 || op == 5'd8) wreg = insn[26:22];
        else                  wreg = 5'd0;
        md = (op == 5'd0) && (alu == 5'd6 || alu == 5'd7);
    endfunction

    function automatic logic [31:0] mk_insn(input logic [4:0] op, input logic [4:0] rd,
                                            input logic [4:0] alu);
        return {op, rd, 15'($urandom), alu, 2'($urandom)};
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [4:0] op;
        logic [4:0] alu;
        int sel;
        sel = $urandom_range(0, 13);
        if (sel < 11) op = legal_ops[sel];
        else          op = 5'($urandom);
        if ($urandom_range(0, 2) == 0) alu = ($urandom_range(0, 1) == 0) ? 5'd6 : 5'd7;
        else                           alu = 5'($urandom);
        return mk_insn(op, 5'($urandom), alu);
    endfunction

    task automatic model_reset();
        m_has     = 0;
        m_wait    = 0;
        m_ctrl    = '0;
        m_wreg    = '0;
        m_retired = 0;
        m_stall   = 0;
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic step(input logic f, input logic iv, input logic [31:0] insn, input logic ordy);
        bit          exp_valid;
        bit          exp_busy;
        bit          exp_ready;
        logic [14:0] d_ctrl;
        logic [4:0]  d_wreg;
        bit          d_md;
        @(negedge clock);
        flush     = f;
        in_valid  = iv;
        in_insn   = insn;
        out_ready = ordy;
        #1;
        exp_valid = m_has && (m_wait == 0);
        exp_busy  = m_has && (m_wait != 0);
        exp_ready = !f && (!m_has || (exp_valid && ordy));
        check_value("out_valid", 32'(out_valid), 32'(exp_valid));
        check_value("md_busy", 32'(md_busy), 32'(exp_busy));
        check_value("in_ready", 32'(in_ready), 32'(exp_ready));
        if (exp_valid) begin
            check_value("out_ctrl", 32'(out_ctrl), 32'(m_ctrl));
            check_value("out_wreg", 32'(out_wreg), 32'(m_wreg));
        end
`ifdef CTRL_DECODE_PIPE_PERF_EN
        check_value("perf_retired", perf_retired, m_retired);
        check_value("perf_stall", perf_stall, m_stall);
`else
        check_value("perf_retired", perf_retired, 32'd0);
        check_value("perf_stall", perf_stall, 32'd0);
`endif
        if (exp_valid && ordy) m_retired = m_retired + 1;
        if (iv && !exp_ready)  m_stall   = m_stall + 1;
        if (f) begin
            m_has  = 0;
            m_wait = 0;
        end else if (iv && exp_ready) begin
            expect_decode(insn, d_ctrl, d_wreg, d_md);
            m_has  = 1;
            m_ctrl = d_ctrl;
            m_wreg = d_wreg;
            m_wait = d_md ? MD : 0;
        end else if (m_has && m_wait > 0) begin
            m_wait = m_wait - 1;
        end else if (exp_valid && ordy) begin
            m_has = 0;
        end
    endtask

    // Observe the DUT just after the edge that consumes the last stepped inputs.
    task automatic peek_after_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        legal_ops[0]  = 5'd0;  legal_ops[1]  = 5'd1;  legal_ops[2]  = 5'd2;
        legal_ops[3]  = 5'd3;  legal_ops[4]  = 5'd4;  legal_ops[5]  = 5'd5;
        legal_ops[6]  = 5'd6;  legal_ops[7]  = 5'd7;  legal_ops[8]  = 5'd8;
        legal_ops[9]  = 5'd21; legal_ops[10] = 5'd22;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_insn   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_md_busy", 32'(md_busy), 32'd0);
        check_value("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        check_value("rst_out_wreg", 32'(out_wreg), 32'd0);
        check_value("rst_perf_retired", perf_retired, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // addi r5
        step(1'b0, 1'b1, mk_insn(5'd5, 5'd5, 5'd0), 1'b1);
        peek_after_edge();
        check_value("addi_valid", 32'(out_valid), 32'd1);
        check_value("addi_ctrl", 32'(out_ctrl), 32'h0005);
        check_value("addi_wreg", 32'(out_wreg), 32'd5);

        // jal then setx back-to-back
        step(1'b0, 1'b1, mk_insn(5'd3, 5'd7, 5'd0), 1'b1);
        peek_after_edge();
        check_value("jal_ctrl", 32'(out_ctrl), 32'h0221);
        check_value("jal_wreg", 32'(out_wreg), 32'd31);
        step(1'b0, 1'b1, mk_insn(5'd21, 5'd9, 5'd0), 1'b1);
        peek_after_edge();
        check_value("setx_ctrl", 32'(out_ctrl), 32'h0801);
        check_value("setx_wreg", 32'(out_wreg), 32'd30);
        step(1'b0, 1'b0, 32'd0, 1'b1);

        // mult waits MD cycles
        step(1'b0, 1'b1, mk_insn(5'd0, 5'd3, 5'd6), 1'b1);
        for (int i = 0; i < MD; i++) step(1'b0, 1'b1, rand_insn(), 1'b1);
        peek_after_edge();
        check_value("mult_valid", 32'(out_valid), 32'd1);
        check_value("mult_ctrl", 32'(out_ctrl), 32'h1001);
        step(1'b0, 1'b0, 32'd0, 1'b1);

        // illegal opcode, then output held under backpressure
        step(1'b0, 1'b1, mk_insn(5'd31, 5'd12, 5'd0), 1'b1);
        peek_after_edge();
        check_value("illegal_ctrl", 32'(out_ctrl), 32'h4000);
        check_value("illegal_wreg", 32'(out_wreg), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, rand_insn(), 1'b0);
            check_value("hold_ctrl", 32'(out_ctrl), 32'h4000);
            check_value("hold_ready", 32'(in_ready), 32'd0);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);

        // flush during mult/div wait
        step(1'b0, 1'b1, mk_insn(5'd0, 5'd4, 5'd7), 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, rand_insn(), 1'b1);
        peek_after_edge();
        check_value("flush_busy", 32'(md_busy), 32'd0);
        for (int i = 0; i < 2 * MD; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // asynchronous reset mid-wait
        step(1'b0, 1'b1, mk_insn(5'd0, 5'd8, 5'd6), 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_value("arst_md_busy", 32'(md_busy), 32'd0);
        check_value("arst_out_valid", 32'(out_valid), 32'd0);
        check_value("arst_out_ctrl", 32'(out_ctrl), 32'd0);
        check_value("arst_perf_stall", perf_stall, 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 32'd0, 1'b1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0), rand_insn(),
                 ($urandom_range(0, 3) != 0));
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
